uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Serial front end: oversamples async rx line, deframes 8N1 (optionally 8E1) UART
//  characters, presents each byte on a 1-entry valid/ready output register.
//  Sits directly upstream of the byte-consuming control logic; sole producer of its input bytes.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency, Hz
//  BAUD     115_200     line rate; DIV = CLK_HZ/BAUD (integer, >= 4), HALF = DIV/2
//  DATA_W   8           data bits per character, 5..8
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  rx_i         in   1       async serial line, idle high
//  m_valid      out  1       byte available in output register
//  m_ready      in   1       consumer accepts byte when m_valid && m_ready
//  m_data       out  DATA_W  received byte, LSB = first bit on line
//  frame_err    out  1       1-cycle pulse: stop bit sampled 0
//  overrun_err  out  1       1-cycle pulse: byte completed while output full and not draining
//  parity_err   out  1       1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//  - Reset: m_valid=0, m_data=0, all err pulses=0, FSM=IDLE, sync flops=1, counters=0.
//  - rx_i -> 2-flop synchronizer (reset to 1); FSM uses synced value rx_s.
//  - Baud counter counts 0..DIV-1, cleared on every state entry.
//  - FSM: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
//    IDLE : rx_s==0 -> START.
//    START: at count HALF-1 sample; 0 -> DATA (counter restarts, bit index 0); 1 -> IDLE (glitch, no error).
//    DATA : sample every DIV cycles (mid-bit); shift in LSB-first; after bit DATA_W-1 -> PARITY or STOP.
//    PARITY: sample mid-bit; compare against XOR of data bits (even parity) -> STOP.
//    STOP : sample mid-bit. 1 -> deliver byte, -> IDLE. 0 -> frame_err pulse, byte dropped, -> BREAK.
//    BREAK: wait for rx_s==1, -> IDLE (no new start accepted while line held low).
//  - Delivery (cycle after stop-bit sample): if !m_valid or (m_valid && m_ready) -> load m_data,
//    m_valid=1. If m_valid && !m_ready -> old byte kept, new dropped, overrun_err pulse.
//  - Simultaneous accept + delivery: old byte consumed, new byte loaded same edge, no overrun.
//  - m_data stable while m_valid && !m_ready; m_valid drops the cycle after acceptance unless reloaded.
//  - Parity mismatch: parity_err pulse with delivery cycle; byte still delivered (consumer decides).
//  - Latency: falling start edge (at rx_s) to m_valid = HALF + (DATA_W[+1]+1)*DIV + 1 cycles.
//  - rst mid-frame: partial character discarded, FSM to IDLE next edge; a line already low
//    after reset is treated as a start bit (frame_err/BREAK handles it if it's a break).
// CONFIGURATION
//  UART_RX_PARITY_EN defined  : PARITY state present, 8E1 frame, parity_err live.
//  UART_RX_PARITY_EN undefined: no PARITY state, 8N1 frame, parity_err driven constant 0.
// STRUCTURE
//  Package uart_pkg: rx_state_t enum (IDLE..BREAK), function baud_div(CLK_HZ,BAUD),
//  localparam PARITY_EVEN=1.
//  One sub-module: uart_bit_sync (2-flop synchronizer, reset value parameter).
//  Baud counter, bit counter, shift register, output register inline.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, HALF=5)
//  1. Send 0xA5, 8N1, m_ready=1 -> m_valid pulse 1 cycle, m_data=0xA5, no err flags.
//  2. 3-cycle low glitch on idle line -> FSM back to IDLE, m_valid=0, no err pulses.
//  3. Send 0x3C with stop bit forced 0, then line high 20 cycles, send 0x55 -> frame_err
//     pulse once, 0x3C never delivered, 0x55 delivered.
//  4. m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, overrun_err pulse on 0x22;
//     raise m_ready -> 0x11 accepted, m_valid=0.
//  5. m_ready asserted exactly in 0x22 delivery cycle with 0x11 held -> 0x11 accepted,
//     m_data=0x22 next cycle, no overrun.
//  6. rst held 1 cycle mid-DATA of 0x7E, line idle after -> no delivery, no errs; with
//     UART_RX_PARITY_EN, 0x07 sent with wrong parity -> m_data=0x07 with parity_err pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // 1 selects even parity: the parity bit makes the total count of ones even.
    localparam int unsigned PARITY_EVEN = 1;

    // Clock cycles per bit on the line.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages reset to the line's idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes rx_i, deframes 8N1 characters and holds each
// received byte in a single-entry valid/ready output register.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with a live parity_err.
module uart_rx_frame #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              parity_err
);

    import uart_pkg::*;

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              rx_s;
    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              state_chg;
    logic              shift_en;
    logic              deliver;
    logic              frame_hit;

    uart_bit_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_load;
    logic par_bad;
    logic par_exp;

    assign par_exp = (^shreg) ^ (PARITY_EVEN != 1);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle sample strobes.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_MID) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    par_load  = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    if (rx_s) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_hit = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        state_chg = (state_nxt != state);
    end

    // Baud counter: wraps every DIV cycles, restarts on every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_chg || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_chg && state_nxt == DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict captured mid parity bit, reported with the delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if (par_load) begin
            par_bad <= (rx_s != par_exp);
        end
    end
`endif

    // Output register: acceptance and a new delivery can share one edge, so the
    // clear on handshake is overridden by the load below when both happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_data      <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= frame_hit;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (deliver) begin
                if (!m_valid || m_ready) begin
                    m_valid <= 1'b1;
                    m_data  <= shreg;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par_bad;
`endif
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at DIV=10; set UART_RX_PARITY_EN to
// exercise the 8E1 build.
module tb_uart_rx_frame;

    localparam int DIV  = 10;
    localparam int HALF = DIV / 2;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int total;
    int bad;
    int n_acc;
    int n_vcyc;
    int n_fe;
    int n_ov;
    int n_pe;

    logic [7:0] exp_q[$];

    uart_rx_frame #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000),
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        n_acc  = 0;
        n_vcyc = 0;
        n_fe   = 0;
        n_ov   = 0;
        n_pe   = 0;
    endtask

    // Hold one bit for DIV cycles; optionally pulse m_ready in the cycle whose
    // closing edge is the stop-bit sample.
    task automatic drive_bit(input logic b, input logic rdy_pulse);
        rx_i = b;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge clk);
            if (rdy_pulse && k == HALF + 2) m_ready = 1'b1;
            if (rdy_pulse && k == HALF + 3) m_ready = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic rdy_pulse);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d, 1'b0);
`endif
        drive_bit(stop_v, rdy_pulse);
        rx_i = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] d);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
        drive_bit(~(^d), 1'b0);
        drive_bit(1'b1, 1'b0);
        rx_i = 1'b1;
    endtask
`endif

    // Monitor: samples just before each rising edge and scores handshakes.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                if (frame_err)   n_fe++;
                if (overrun_err) n_ov++;
                if (parity_err)  n_pe++;
                if (m_valid)     n_vcyc++;
                if (m_valid && m_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got 0x%0h want none", m_data);
                    end else begin
                        chk("byte", int'(m_data), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        clear_counts();
        rst     = 1'b1;
        rx_i    = 1'b1;
        m_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        #4;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun_err", int'(overrun_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);

        // 1: 0xA5 with consumer always ready
        @(negedge clk);
        clear_counts();
        m_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        chk("t1_accepts", n_acc, 1);
        chk("t1_valid_cycles", n_vcyc, 1);
        chk("t1_frame_err", n_fe, 0);
        chk("t1_overrun", n_ov, 0);
        chk("t1_parity_err", n_pe, 0);

        // 2: 3-cycle glitch on idle line
        clear_counts();
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(30);
        chk("t2_accepts", n_acc, 0);
        chk("t2_valid_cycles", n_vcyc, 0);
        chk("t2_frame_err", n_fe, 0);
        chk("t2_overrun", n_ov, 0);

        // 3: bad stop bit on 0x3C, then a good 0x55
        clear_counts();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        chk("t3_frame_err_first", n_fe, 1);
        chk("t3_no_delivery", n_vcyc, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);
        chk("t3_frame_err_total", n_fe, 1);
        chk("t3_accepts", n_acc, 1);

        // 4: stalled consumer, second byte overruns
        clear_counts();
        m_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(5);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        #4;
        chk("t4_overrun", n_ov, 1);
        chk("t4_hold_valid", int'(m_valid), 1);
        chk("t4_hold_data", int'(m_data), 8'h11);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        #4;
        chk("t4_valid_drop", int'(m_valid), 0);
        chk("t4_accepts", n_acc, 1);

        // 5: acceptance in the same edge as the next load
        @(negedge clk);
        clear_counts();
        m_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(5);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(3);
        #4;
        chk("t5_valid", int'(m_valid), 1);
        chk("t5_data", int'(m_data), 8'h22);
        chk("t5_overrun", n_ov, 0);
        chk("t5_accepts_first", n_acc, 1);
        @(negedge clk);
        m_ready = 1'b1;
        idle(3);
        chk("t5_accepts_total", n_acc, 2);

        // 6: reset in the middle of 0x7E, then idle line
        clear_counts();
        rx_i = 1'b0;
        idle(DIV);
        rx_i = 1'b0;
        idle(DIV);
        rx_i = 1'b1;
        idle(HALF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(150);
        chk("t6_accepts", n_acc, 0);
        chk("t6_valid_cycles", n_vcyc, 0);
        chk("t6_frame_err", n_fe, 0);
        chk("t6_overrun", n_ov, 0);
        chk("t6_parity_err", n_pe, 0);

`ifdef UART_RX_PARITY_EN
        // 6b: wrong parity still delivers the byte, flagged
        clear_counts();
        exp_q.push_back(8'h07);
        send_frame_badpar(8'h07);
        idle(20);
        chk("t6p_parity_err", n_pe, 1);
        chk("t6p_accepts", n_acc, 1);
        chk("t6p_frame_err", n_fe, 0);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
